// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter: coherence-controller data port vs two instruction ports.
// Data wins by default with burst lock; a saturating starve counter bounds how long instructions wait.
module memory_arbiter #(
    parameter int DSTARVE_MAX = 8
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ccREN,
    input  logic            ccWEN,
    input  logic [31:0]     ccaddr,
    input  logic [31:0]     ccstore,
    output logic            ccwait,
    output logic [31:0]     ccload,
    input  logic [1:0]      iREN,
    input  logic [1:0][31:0] iaddr,
    output logic [1:0]      iwait,
    output logic [1:0][31:0] iload,
    output logic            ramREN,
    output logic            ramWEN,
    output logic [31:0]     ramaddr,
    output logic [31:0]     ramstore,
    input  logic [1:0]      ramstate,
    input  logic [31:0]     ramload,
    output logic            ramerr
);
    localparam int SW = $clog2(DSTARVE_MAX) + 1;
    localparam logic [SW-1:0] SMAX = SW'(DSTARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT0, IGRANT1} state_t;

    state_t         state, state_next;
    logic           rr_ptr, rr_ptr_next;
    logic [SW-1:0]  starve, starve_next;
    logic           data_req, access, dcomplete, icomplete, icore, gcore;

    assign data_req  = ccREN | ccWEN;
    assign access    = (ramstate == RAM_ACCESS);
    assign gcore     = (state == IGRANT1);
    assign dcomplete = (state == DGRANT) && data_req && access;
    assign icomplete = ((state == IGRANT0) || (state == IGRANT1)) && iREN[gcore] && access;
    // rr_ptr names the core served last, so on a tie the other core goes next
    assign icore     = (&iREN) ? ~rr_ptr : iREN[1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;
            starve <= '0;
            ramerr <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            starve <= starve_next;
            if (state != IDLE && ramstate == RAM_ERROR)
                ramerr <= 1'b1;
        end
    end

    always_comb begin
        starve_next = starve;
        if (icomplete || iREN == 2'b00)
            starve_next = '0;
        else if (dcomplete && starve != SMAX)
            starve_next = starve + 1'b1;
    end

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        ccwait      = 1'b1;
        ccload      = '0;
        iwait       = 2'b11;
        iload       = '0;
        case (state)
            IDLE: begin
                if (|iREN && (!data_req || starve == SMAX))
                    state_next = icore ? IGRANT1 : IGRANT0;
                else if (data_req)
                    state_next = DGRANT;
            end
            DGRANT: begin
                // simultaneous read and write is treated as a write
                ramWEN   = ccWEN;
                ramREN   = ccREN & ~ccWEN;
                ramaddr  = ccaddr;
                ramstore = ccstore;
                ccload   = ramload;
                if (dcomplete)
                    ccwait = 1'b0;
                // burst lock holds the grant unless instructions have starved long enough
                if (!data_req)
                    state_next = IDLE;
                else if (dcomplete && starve_next == SMAX && |iREN)
                    state_next = IDLE;
            end
            IGRANT0, IGRANT1: begin
                ramREN        = 1'b1;
                ramaddr       = iaddr[gcore];
                iload[gcore]  = ramload;
                if (!iREN[gcore]) begin
                    state_next = IDLE;
                end else if (access) begin
                    iwait[gcore] = 1'b0;
                    rr_ptr_next  = gcore;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter.
// Queued requesters and a latency-randomised RAM, checked against a memory model plus ordering rules.
module tb_memory_arbiter;
    localparam int DSTARVE_MAX = 8;

    logic            CLK, nRST;
    logic            ccREN, ccWEN;
    logic [31:0]     ccaddr, ccstore, ccload;
    logic            ccwait;
    logic [1:0]      iREN, iwait;
    logic [1:0][31:0] iaddr, iload;
    logic            ramREN, ramWEN, ramerr;
    logic [31:0]     ramaddr, ramstore, ramload;
    logic [1:0]      ramstate;

    memory_arbiter #(.DSTARVE_MAX(DSTARVE_MAX)) dut (
        .CLK(CLK), .nRST(nRST),
        .ccREN(ccREN), .ccWEN(ccWEN), .ccaddr(ccaddr), .ccstore(ccstore),
        .ccwait(ccwait), .ccload(ccload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramstate(ramstate), .ramload(ramload), .ramerr(ramerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          wr;
        bit          both;
    } dreq_t;

    dreq_t       dq[$];
    logic [31:0] iq0[$], iq1[$];
    logic [31:0] mem [64];
    int          ev[$];
    int          checks = 0, failures = 0;
    int          busy_left = -1, fixed_busy = 0, ren_cycles = 0, streak = 0;
    bit          rand_lat = 0;
    bit [1:0]    cont = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic icomplete(input int n, input logic [31:0] a);
        check("i_addr", ramaddr, a);
        check("i_load", iload[n], mem[a[7:2]]);
        check("i_other_load", iload[1-n], 32'h0);
        check("i_cc_load", ccload, 32'h0);
        // the other core must not be passed over twice while it waits
        check("i_fair", {31'b0, cont[1-n]}, 32'h0);
        ev.push_back(n + 1);
        streak     = 0;
        cont[n]    = 1'b0;
        cont[1-n]  = iREN[1-n];
    endtask

    task automatic step();
        @(negedge CLK);
        if (dq.size() > 0) begin
            ccREN   = !dq[0].wr || dq[0].both;
            ccWEN   = dq[0].wr;
            ccaddr  = dq[0].addr;
            ccstore = dq[0].data;
        end else begin
            ccREN = 1'b0;
            ccWEN = 1'b0;
        end
        iREN[0] = (iq0.size() > 0);
        if (iREN[0]) iaddr[0] = iq0[0];
        iREN[1] = (iq1.size() > 0);
        if (iREN[1]) iaddr[1] = iq1[0];
        #1;
        if (ramREN || ramWEN) begin
            if (busy_left < 0) busy_left = rand_lat ? int'($urandom_range(0, 2)) : fixed_busy;
            if (busy_left > 0) begin
                ramstate = 2'd1;
                busy_left--;
            end else begin
                ramstate  = 2'd2;
                ramload   = mem[ramaddr[7:2]];
                busy_left = -1;
            end
        end else begin
            ramstate  = 2'd0;
            busy_left = -1;
        end
        #1;
        if (ramREN) ren_cycles++;
        check("strobe_excl", {31'b0, ramREN & ramWEN}, 32'h0);
        check("one_done", {31'b0, $countones({~ccwait, ~iwait}) <= 1}, 32'h1);
        if (!ccwait) begin
            check("d_pending", {31'b0, dq.size() > 0}, 32'h1);
            if (dq.size() > 0) begin
                check("d_addr", ramaddr, dq[0].addr);
                check("d_iload", iload, 64'h0);
                if (dq[0].wr) begin
                    check("d_wen", {31'b0, ramWEN}, 32'h1);
                    check("d_store", ramstore, dq[0].data);
                    mem[dq[0].addr[7:2]] = dq[0].data;
                end else begin
                    check("d_load", ccload, mem[dq[0].addr[7:2]]);
                end
                streak = (iREN != 2'b00) ? streak + 1 : 0;
                check("starve_bound", {31'b0, streak <= DSTARVE_MAX}, 32'h1);
                ev.push_back(0);
                void'(dq.pop_front());
            end
        end
        if (!iwait[0]) begin
            check("i0_pending", {31'b0, iq0.size() > 0}, 32'h1);
            if (iq0.size() > 0) begin
                icomplete(0, iq0[0]);
                void'(iq0.pop_front());
            end
        end
        if (!iwait[1]) begin
            check("i1_pending", {31'b0, iq1.size() > 0}, 32'h1);
            if (iq1.size() > 0) begin
                icomplete(1, iq1[0]);
                void'(iq1.pop_front());
            end
        end
        if (iREN == 2'b00) streak = 0;
        for (int m = 0; m < 2; m++)
            if (!iREN[m]) cont[m] = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((dq.size() + iq0.size() + iq1.size()) > 0 && c < maxc) begin
            step();
            c++;
        end
        check("drain", dq.size() + iq0.size() + iq1.size(), 32'h0);
        step();
        step();
    endtask

    initial begin
        int    e33[3] = '{1, 2, 1};
        int    e34[3] = '{0, 0, 1};
        dreq_t r;
        nRST = 1'b0;
        ccREN = 1'b0; ccWEN = 1'b0; ccaddr = '0; ccstore = '0;
        iREN = 2'b00; iaddr = '0; ramstate = 2'd0; ramload = '0;
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        mem[16] = 32'hDEADBEEF;

        @(negedge CLK); #1;
        check("rst_ren", {31'b0, ramREN}, 32'h0);
        check("rst_wen", {31'b0, ramWEN}, 32'h0);
        check("rst_ccwait", {31'b0, ccwait}, 32'h1);
        check("rst_iwait", {30'b0, iwait}, 32'h3);
        check("rst_ccload", ccload, 32'h0);
        check("rst_iload", iload, 64'h0);
        check("rst_ramaddr", ramaddr, 32'h0);
        check("rst_ramerr", {31'b0, ramerr}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // single read with two BUSY cycles
        fixed_busy = 2; ren_cycles = 0; ev.delete();
        dq.push_back('{32'h40, 32'h0, 1'b0, 1'b0});
        step();
        check("arb_latency", {31'b0, ramREN}, 32'h0);
        drain(20);
        check("rd_ren_cycles", ren_cycles, 32'd3);
        check("rd_events", ev.size(), 32'd1);
        check("rd_value", mem[16], 32'hDEADBEEF);

        // both cores requesting: round robin starting with core 0
        fixed_busy = 0; ev.delete();
        iq0.push_back(32'h100); iq0.push_back(32'h108); iq1.push_back(32'h204);
        drain(40);
        check("rr_n", ev.size(), 32'd3);
        for (int k = 0; k < 3; k++) check("rr_order", (k < ev.size()) ? ev[k] : -1, e33[k]);

        // two-word data burst ahead of a waiting core 0
        fixed_busy = 1; ev.delete();
        dq.push_back('{32'h80, 32'h0, 1'b0, 1'b0});
        dq.push_back('{32'h84, 32'h0, 1'b0, 1'b0});
        iq0.push_back(32'h10C);
        drain(40);
        check("burst_n", ev.size(), 32'd3);
        for (int k = 0; k < 3; k++) check("burst_order", (k < ev.size()) ? ev[k] : -1, e34[k]);

        // long write stream starves core 1 until the limit
        fixed_busy = 0; ev.delete();
        for (int k = 0; k < 10; k++) dq.push_back('{32'hC0 + 32'(4 * k), $urandom, 1'b1, 1'b0});
        iq1.push_back(32'h3F0);
        drain(80);
        check("starve_n", ev.size(), 32'd11);
        for (int k = 0; k < 11; k++)
            check("starve_order", (k < ev.size()) ? ev[k] : -1, (k == DSTARVE_MAX) ? 2 : 0);

        // instruction request withdrawn before ACCESS
        @(negedge CLK); iREN = 2'b01; iaddr[0] = 32'h44; ramstate = 2'd1;
        @(negedge CLK); #1;
        check("abort_grant", {31'b0, ramREN}, 32'h1);
        check("abort_wait", {30'b0, iwait}, 32'h3);
        @(negedge CLK); iREN = 2'b00; #1;
        check("abort_nopulse", {30'b0, iwait}, 32'h3);
        @(negedge CLK); ramstate = 2'd0; #1;
        check("abort_idle", {31'b0, ramREN}, 32'h0);

        // asynchronous reset in the middle of a data grant
        @(negedge CLK); ccREN = 1'b1; ccaddr = 32'h48; ramstate = 2'd1;
        @(negedge CLK); #1;
        check("rst_pre_ren", {31'b0, ramREN}, 32'h1);
        #2; nRST = 1'b0; #1;
        check("rst_async_ren", {31'b0, ramREN}, 32'h0);
        check("rst_async_wait", {31'b0, ccwait}, 32'h1);
        @(negedge CLK); ccREN = 1'b0; ramstate = 2'd0; nRST = 1'b1;

        // ERROR under a grant is sticky until reset
        @(negedge CLK); ccWEN = 1'b1; ccaddr = 32'h4C; #1;
        check("err_clear", {31'b0, ramerr}, 32'h0);
        @(negedge CLK); ramstate = 2'd3; #1;
        check("err_hold_wen", {31'b0, ramWEN}, 32'h1);
        check("err_hold_wait", {31'b0, ccwait}, 32'h1);
        @(negedge CLK); #1;
        check("err_set", {31'b0, ramerr}, 32'h1);
        @(negedge CLK); ccWEN = 1'b0; ramstate = 2'd0;
        repeat (3) @(negedge CLK);
        #1;
        check("err_sticky", {31'b0, ramerr}, 32'h1);
        nRST = 1'b0; #1;
        check("err_reset", {31'b0, ramerr}, 32'h0);
        @(negedge CLK); nRST = 1'b1;
        streak = 0; cont = 2'b00;

        // random traffic against the memory model and ordering rules
        rand_lat = 1;
        for (int c = 0; c < 3000; c++) begin
            if (dq.size() == 0 && $urandom_range(0, 3) == 0) begin
                int n = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(1, 3));
                for (int k = 0; k < n; k++) begin
                    r.addr = 32'($urandom_range(0, 63)) << 2;
                    r.data = $urandom;
                    r.wr   = 1'($urandom_range(0, 1));
                    r.both = r.wr && ($urandom_range(0, 1) == 1);
                    dq.push_back(r);
                end
            end
            if (iq0.size() == 0 && $urandom_range(0, 3) == 0) iq0.push_back(32'($urandom_range(0, 63)) << 2);
            if (iq1.size() == 0 && $urandom_range(0, 3) == 0) iq1.push_back(32'($urandom_range(0, 63)) << 2);
            step();
        end
        drain(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL provide parameter DSTARVE_MAX, default 8, max consecutive data accesses granted while any instruction request waits.
REQ-002 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ccREN  input  1  data read request from coherence controller.
REQ-005 SHALL have port ccWEN  input  1  data write request from coherence controller.
REQ-006 SHALL have port ccaddr  input  32  data word address.
REQ-007 SHALL have port ccstore  input  32  data write value.
REQ-008 SHALL have port ccwait  output  1  low for exactly the cycle the data access completes.
REQ-009 SHALL have port ccload  output  32  read data, valid when ccwait low on a read.
REQ-010 SHALL have port iREN  input  2  per-core instruction read request.
REQ-011 SHALL have port iaddr  input  2x32  per-core instruction address.
REQ-012 SHALL have port iwait  output  2  per-core, low for exactly the completing cycle.
REQ-013 SHALL have port iload  output  2x32  per-core instruction data, valid when iwait[n] low.
REQ-014 SHALL have port ramREN, ramWEN  output  1 each  RAM read/write strobes, never both high.
REQ-015 SHALL have port ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 SHALL have port ramstate  input  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.
REQ-017 SHALL have port ramload  input  32  RAM read data, valid when ramstate=ACCESS.
REQ-018 SHALL have port ramerr  output  1  sticky flag, set when ramstate=ERROR seen under a grant.

Function
REQ-019 SHALL implement FSM states IDLE, DGRANT, IGRANT0, IGRANT1; grant decided in IDLE, registered, so first RAM strobe appears the cycle after the request is seen (1-cycle arbitration latency).
REQ-020 IDLE SHALL drive all strobes 0, all waits 1, ramaddr/ramstore 0.
REQ-021 IDLE priority: data (ccREN|ccWEN) over instruction, unless starve counter = DSTARVE_MAX and any iREN high, then instruction wins.
REQ-022 Between instruction requesters SHALL use round-robin: pointer names the core last served; the other core wins a tie; pointer updates on IGRANTn completion.
REQ-023 DGRANT SHALL pass ccREN/ccWEN/ccaddr/ccstore to RAM, ccload=ramload; ccwait=0 only when ramstate=ACCESS.
REQ-024 DGRANT SHALL remain (burst lock) while ccREN|ccWEN high after an ACCESS, so back-to-back burst words proceed without re-arbitration; exits to IDLE the cycle after both drop.
REQ-025 Starve counter (saturating, width clog2(DSTARVE_MAX)+1) SHALL increment per data ACCESS while any iREN high, clear on any instruction completion or when iREN=0.
REQ-026 IGRANTn SHALL drive ramREN=1, ramaddr=iaddr[n], iload[n]=ramload, iwait[n]=0 on ACCESS, then return to IDLE (single-word grant).
REQ-027 If iREN[n] drops during IGRANTn before ACCESS, SHALL return to IDLE with no completion pulse.
REQ-028 Non-granted requester SHALL see wait=1 and its load=0.
REQ-029 ramstate BUSY/FREE/ERROR SHALL hold the grant with wait=1; ERROR sets ramerr, cleared only by reset.
REQ-030 ccREN and ccWEN both high SHALL be treated as a write.

Reset
REQ-031 nRST low SHALL asynchronously force IDLE, round-robin pointer=1 (core 0 wins first tie), starve counter=0, ramerr=0, all strobes 0, waits 1, loads 0, even mid-grant.

Verification
REQ-032 ccREN=1, ccaddr=0x40, RAM BUSY 2 cycles then ACCESS ramload=0xDEADBEEF -> ccwait low exactly one cycle with ccload=0xDEADBEEF; ramREN high 3 cycles.
REQ-033 iREN=2'b11 continuously, no data -> grants alternate core0, core1, core0; each iwait pulse one cycle.
REQ-034 ccREN held across 2-word burst (0x80, 0x84) while iREN[0]=1 -> both data words served before IGRANT0.
REQ-035 ccWEN held 8+ accesses with iREN[1]=1, DSTARVE_MAX=8 -> after 8th data ACCESS, IGRANT1 precedes further data grants.
REQ-036 nRST pulsed low mid-DGRANT -> strobes 0, ccwait=1 immediately; ramstate=3 under grant -> ramerr=1 until reset.
